// File: rtl/issue_scoreboard_pkg.sv
// Shared micro-architecture types for the decode-to-issue scoreboard slice.
// Holds the uop encoding, immediate type and pass-through issue controls.
package issue_scoreboard_pkg;

  localparam int unsigned p_num_arch_regs = 32;

  typedef enum logic [2:0] {
    ImmI,
    ImmS,
    ImmB,
    ImmU,
    ImmJ,
    ImmNone
  } rv_imm_type;

  typedef enum logic [3:0] {
    UopNop,
    UopAdd,
    UopAddi,
    UopSub,
    UopLw,
    UopSw,
    UopBeq,
    UopJal,
    UopJalr,
    UopLui
  } rv_uop;

  typedef struct packed {
    rv_imm_type  imm_sel;
    logic [1:0]  op2_sel;
    logic [1:0]  jal;
    logic [1:0]  op3_sel;
  } rv_issue_ctrl;

  localparam rv_issue_ctrl IssueCtrlRst = '{
    imm_sel: ImmNone,
    op2_sel: 2'b00,
    jal:     2'b00,
    op3_sel: 2'b00
  };

endpackage

// File: rtl/issue_scoreboard_sb_counter_array.sv
// Per-architectural-register saturating pending-write counters (x0 never tracked).
// ISSUE_SB_CMP_BYPASS_EN: busy/sat flags see the same-cycle writeback decrement.
module issue_scoreboard_sb_counter_array
  import issue_scoreboard_pkg::*;
#(
  parameter int unsigned p_cnt_bits = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       inc,
  input  logic [4:0]                 inc_addr,
  input  logic                       dec,
  input  logic [4:0]                 dec_addr,
  output logic [p_num_arch_regs-1:0] busy,
  output logic [p_num_arch_regs-1:0] sat,
  output logic                       all_zero
);

  localparam logic [p_cnt_bits-1:0] CntMax = '1;
  localparam logic [p_cnt_bits-1:0] CntOne = p_cnt_bits'(1);

  logic [p_cnt_bits-1:0]      cnt_q [p_num_arch_regs];
  logic [p_cnt_bits-1:0]      cnt_d [p_num_arch_regs];
  logic [p_num_arch_regs-1:0] inc_hit;
  logic [p_num_arch_regs-1:0] dec_hit;

  always_comb begin
    inc_hit = '0;
    dec_hit = '0;
    for (int unsigned r = 1; r < p_num_arch_regs; r++) begin
      inc_hit[r] = inc && (inc_addr == 5'(r));
      dec_hit[r] = dec && (dec_addr == 5'(r));
    end
  end

  // Simultaneous inc and dec on one register cancel out.
  always_comb begin
    for (int unsigned r = 0; r < p_num_arch_regs; r++) begin
      cnt_d[r] = cnt_q[r];
      if (r == 0) begin
        cnt_d[r] = '0;
      end else if (inc_hit[r] && !dec_hit[r]) begin
        if (cnt_q[r] != CntMax) cnt_d[r] = cnt_q[r] + CntOne;
      end else if (dec_hit[r] && !inc_hit[r]) begin
        if (cnt_q[r] != '0) cnt_d[r] = cnt_q[r] - CntOne;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned r = 0; r < p_num_arch_regs; r++) cnt_q[r] <= '0;
    end else begin
      for (int unsigned r = 0; r < p_num_arch_regs; r++) cnt_q[r] <= cnt_d[r];
    end
  end

  always_comb begin
    busy = '0;
    sat  = '0;
    for (int unsigned r = 1; r < p_num_arch_regs; r++) begin
`ifdef ISSUE_SB_CMP_BYPASS_EN
      busy[r] = (cnt_q[r] != '0) && !(dec_hit[r] && (cnt_q[r] == CntOne));
      sat[r]  = (cnt_q[r] == CntMax) && !dec_hit[r];
`else
      busy[r] = cnt_q[r] != '0;
      sat[r]  = cnt_q[r] == CntMax;
`endif
    end
  end

  always_comb begin
    all_zero = 1'b1;
    for (int unsigned r = 0; r < p_num_arch_regs; r++) begin
      if (cnt_q[r] != '0) all_zero = 1'b0;
    end
  end

`ifndef SYNTHESIS
  // A writeback with nothing pending points at a broken producer upstream.
  always_ff @(posedge clk) begin
    if (rst_n && dec && (dec_addr != 5'd0) && !inc_hit[dec_addr]) begin
      assert (cnt_q[dec_addr] != '0)
        else $error("writeback to x%0d with no pending write", dec_addr);
    end
  end
`endif

endmodule

// File: rtl/issue_scoreboard.sv
// Decode-to-issue stage: one-entry uop holding register plus RAW/WAW scoreboard.
// Define ISSUE_SB_CMP_BYPASS_EN to let a same-cycle writeback clear a hazard.
module issue_scoreboard
  import issue_scoreboard_pkg::*;
#(
  parameter int unsigned p_cnt_bits = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         dec_val,
  output logic         dec_rdy,
  input  rv_uop        dec_uop,
  input  logic [4:0]   dec_raddr0,
  input  logic [4:0]   dec_raddr1,
  input  logic [4:0]   dec_waddr,
  input  logic         dec_wen,
  input  rv_issue_ctrl dec_ctrl,
  output logic         iss_val,
  input  logic         iss_rdy,
  output rv_uop        iss_uop,
  output logic [4:0]   iss_raddr0,
  output logic [4:0]   iss_raddr1,
  output logic [4:0]   iss_waddr,
  output logic         iss_wen,
  output rv_issue_ctrl iss_ctrl,
  input  logic         cmp_val,
  input  logic [4:0]   cmp_waddr,
  input  logic         squash,
  output logic         sb_empty
);

  logic         val_q, val_d;
  rv_uop        uop_q;
  logic [4:0]   raddr0_q, raddr1_q, waddr_q;
  logic         wen_q;
  rv_issue_ctrl ctrl_q;

  logic [p_num_arch_regs-1:0] busy;
  logic [p_num_arch_regs-1:0] sat;
  logic hazard, fire, accept, sb_inc, sb_dec;

  issue_scoreboard_sb_counter_array #(
    .p_cnt_bits (p_cnt_bits)
  ) u_sb (
    .clk      (clk),
    .rst_n    (rst_n),
    .inc      (sb_inc),
    .inc_addr (waddr_q),
    .dec      (sb_dec),
    .dec_addr (cmp_waddr),
    .busy     (busy),
    .sat      (sat),
    .all_zero (sb_empty)
  );

  // WAW is tolerated until the destination counter saturates.
  always_comb begin
    hazard = 1'b0;
    if ((raddr0_q != 5'd0) && busy[raddr0_q]) hazard = 1'b1;
    if ((raddr1_q != 5'd0) && busy[raddr1_q]) hazard = 1'b1;
    if (wen_q && (waddr_q != 5'd0) && sat[waddr_q]) hazard = 1'b1;
  end

  always_comb begin
    iss_val = val_q && !hazard && !squash;
    fire    = iss_val && iss_rdy;
    dec_rdy = !squash && (!val_q || fire);
    accept  = dec_val && dec_rdy;
    sb_inc  = fire && wen_q && (waddr_q != 5'd0);
    sb_dec  = cmp_val && (cmp_waddr != 5'd0);
  end

  always_comb begin
    val_d = val_q;
    if (squash)      val_d = 1'b0;
    else if (accept) val_d = 1'b1;
    else if (fire)   val_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      val_q    <= 1'b0;
      uop_q    <= UopNop;
      raddr0_q <= 5'd0;
      raddr1_q <= 5'd0;
      waddr_q  <= 5'd0;
      wen_q    <= 1'b0;
      ctrl_q   <= IssueCtrlRst;
    end else begin
      val_q <= val_d;
      if (accept) begin
        uop_q    <= dec_uop;
        raddr0_q <= dec_raddr0;
        raddr1_q <= dec_raddr1;
        waddr_q  <= dec_waddr;
        wen_q    <= dec_wen;
        ctrl_q   <= dec_ctrl;
      end
    end
  end

  assign iss_uop    = uop_q;
  assign iss_raddr0 = raddr0_q;
  assign iss_raddr1 = raddr1_q;
  assign iss_waddr  = waddr_q;
  assign iss_wen    = wen_q;
  assign iss_ctrl   = ctrl_q;

endmodule
